// File: rtl/tm1638_disp_arb.sv
// Display-ownership arbiter and refresh-paced frame scheduler for a TM1638 driver.
// Two requesters share the panel. The owner's frame is latched at each refresh and handed to the driver.
module tm1638_disp_arb #(
    parameter int         REFRESH_DIV = 50000,
    parameter int         DWELL       = 8,
    parameter logic [3:0] BLANK       = 4'hF
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [7:0]  frm0_led,
    input  logic [31:0] frm0_dig,
    input  logic [7:0]  frm1_led,
    input  logic [31:0] frm1_dig,
    output logic [1:0]  gnt,
    output logic [7:0]  drv_led,
    output logic [31:0] drv_dig,
    output logic        drv_start,
    input  logic        drv_busy,
    output logic [7:0]  frame_cnt,
    output logic        overrun
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [2:0] {IDLE, LATCH, START, WAIT_ACK, WAIT_DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             pend;
    logic [7:0]       dwell_cnt;
    logic             last;
    logic             done;
    logic             own_idx;
    logic             keep;
    logic [1:0]       gnt_nxt;

    assign tick = (tick_cnt == CNT_W'(REFRESH_DIV - 1));
    assign done = (state == WAIT_DONE) && !drv_busy;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            pend     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
            // A tick landing in LATCH re-arms pend instead of being consumed.
            if (tick)
                pend <= 1'b1;
            else if (state == LATCH)
                pend <= 1'b0;
            if (tick && pend)
                overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // A tick seen in IDLE counts as pending so LATCH follows it directly.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pend || tick) state_nxt = LATCH;
            LATCH:     state_nxt = START;
            START:     state_nxt = WAIT_ACK;
            WAIT_ACK:  if (drv_busy) state_nxt = WAIT_DONE;
            WAIT_DONE: if (!drv_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        drv_start = (state == START);
    end

    // Keep the owner while it requests and either its dwell is unspent or nobody else wants the panel.
    assign own_idx = gnt[1];
    assign keep    = (|gnt) && req[own_idx] && ((dwell_cnt < 8'(DWELL)) || !req[~own_idx]);

    always_comb begin
        gnt_nxt = req;
        if (keep)
            gnt_nxt = gnt;
        else if (&req)
            gnt_nxt = last ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= 2'b00;
            last      <= 1'b1;
            dwell_cnt <= 8'd0;
            frame_cnt <= 8'd0;
            drv_led   <= 8'd0;
            drv_dig   <= {8{BLANK}};
        end else if (state == LATCH) begin
            gnt <= gnt_nxt;
            if (gnt_nxt != gnt) begin
                dwell_cnt <= 8'd0;
                if (|gnt_nxt)
                    last <= gnt_nxt[1];
            end
            case (gnt_nxt)
                2'b01: begin
                    drv_led <= frm0_led;
                    drv_dig <= frm0_dig;
                end
                2'b10: begin
                    drv_led <= frm1_led;
                    drv_dig <= frm1_dig;
                end
                default: begin
                    drv_led <= 8'd0;
                    drv_dig <= {8{BLANK}};
                end
            endcase
        end else if (done) begin
            frame_cnt <= frame_cnt + 8'd1;
            if (dwell_cnt < 8'(DWELL))
                dwell_cnt <= dwell_cnt + 8'd1;
        end
    end

endmodule
